// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, masked, fixed-priority interrupt request source.
// Define INTC_SYNC_EN to pass each HardwareInterrupt line through a two-flop synchronizer.
module interrupt_controller #(
  parameter int NUM_IRQ = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_IRQ-1:0] HardwareInterrupt,
  input  logic               InterruptTrue,
  input  logic               ReturnFromInt,
  input  logic               MaskWrite,
  input  logic [NUM_IRQ-1:0] MaskData,
  output logic               InterruptIn,
  output logic [NUM_IRQ-1:0] IntCause,
  output logic [2:0]         IntID,
  output logic [NUM_IRQ-1:0] Pending,
  output logic               InService
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [NUM_IRQ-1:0] line, prev_q, pending_q, pending_d, mask_q, cause_q, cause_d, req, win;
  logic [2:0] id_q, id_d, win_id;
`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= HardwareInterrupt;
      sync2_q <= sync1_q;
    end
  assign line = sync2_q;
`else
  assign line = HardwareInterrupt;
`endif
  assign req = pending_q & mask_q;
  // Two's-complement trick isolates the lowest set bit: lowest index wins.
  assign win = req & (~req + NUM_IRQ'(1));
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) win_id = req[i] ? 3'(i) : win_id;
  end
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    id_d      = id_q;
    pending_d = pending_q;
    case (state_q)
      IDLE:
        if (|req) begin
          state_d = REQ;
          cause_d = win;
          id_d    = win_id;
        end
      REQ:
        if (InterruptTrue) begin
          state_d   = SERVICE;
          pending_d = pending_q & ~cause_q;
        end else if (MaskWrite && !(|(MaskData & cause_q))) begin
          state_d = IDLE;
          cause_d = '0;
          id_d    = '0;
        end
      SERVICE:
        if (ReturnFromInt) begin
          state_d = IDLE;
          cause_d = '0;
          id_d    = '0;
        end
      default: state_d = IDLE;
    endcase
    // New edges are ORed in last so a set beats a same-cycle clear.
    pending_d = pending_d | (line & ~prev_q);
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      id_q      <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      prev_q    <= line;
      mask_q    <= MaskWrite ? MaskData : mask_q;
    end
  assign InterruptIn = state_q == REQ;
  assign InService   = state_q == SERVICE;
  assign IntCause    = cause_q;
  assign IntID       = id_q;
  assign Pending     = pending_q;
endmodule
